// File: rtl/rvfpm_chk_pkg.sv
// rvfpm_chk_pkg
// Shared definitions for the FMV.X.W / FMV.W.X result checker:
//   - RISC-V OP-FP encoding constants used to recognise the two moves
//   - chk_kind_e : which move an in-flight entry belongs to
//   - chk_entry_t: one delay-line slot {valid, kind, rd, expected}
// The entry fields are sized for the widest supported configuration
// (XLEN up to 64, register index up to 8 bits). Narrower builds zero-extend
// into them, so the unused upper bits stay constant and synthesis removes them.
package rvfpm_chk_pkg;

  localparam logic [6:0] OPC_OP_FP  = 7'b1010011;
  localparam logic [6:0] F7_FMV_X_W = 7'b1110000;
  localparam logic [6:0] F7_FMV_W_X = 7'b1111000;
  localparam logic [2:0] F3_FMV     = 3'b000;
  localparam logic [4:0] RS2_FMV    = 5'b00000;

  localparam int CHK_DATA_W = 64;
  localparam int CHK_RD_W   = 8;

  typedef enum logic {
    FMV_X_W = 1'b0,
    FMV_W_X = 1'b1
  } chk_kind_e;

  typedef struct packed {
    logic                  valid;
    chk_kind_e             kind;
    logic [CHK_RD_W-1:0]   rd;
    logic [CHK_DATA_W-1:0] expected;
  } chk_entry_t;

  // Common part of both encodings: OP-FP opcode, funct3 = 000, rs2 = 00000.
  function automatic logic is_fmv_common(input logic [31:0] insn);
    return (insn[6:0] == OPC_OP_FP) && (insn[14:12] == F3_FMV) &&
           (insn[24:20] == RS2_FMV);
  endfunction

  function automatic logic is_fmv_x_w(input logic [31:0] insn);
    return is_fmv_common(insn) && (insn[31:25] == F7_FMV_X_W);
  endfunction

  function automatic logic is_fmv_w_x(input logic [31:0] insn);
    return is_fmv_common(insn) && (insn[31:25] == F7_FMV_W_X);
  endfunction

endpackage

// File: rtl/rvfpm_chk_delay_line.sv
// rvfpm_chk_delay_line
// DEPTH-entry shift register of entries of type T. Mirrors the latency of
// the observed FP pipeline: it advances only when that pipeline advances.
// Ports:
//   ck     : clock, rising edge
//   rst    : synchronous active-high reset, all entries cleared (valid=0)
//   enable : shift one position this cycle
//   in     : entry written into stage 0
//   out    : oldest entry (stage DEPTH-1)
module rvfpm_chk_delay_line #(
  parameter int  DEPTH = 4,
  parameter type T     = rvfpm_chk_pkg::chk_entry_t
) (
  input  logic ck,
  input  logic rst,
  input  logic enable,
  input  T     in,
  output T     out
);

  T stage [DEPTH];

  always_ff @(posedge ck) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        stage[i] <= '0;
      end
    end else if (enable) begin
      stage[0] <= in;
      for (int i = 1; i < DEPTH; i++) begin
        stage[i] <= stage[i-1];
      end
    end
  end

  assign out = stage[DEPTH-1];

endmodule

// File: rtl/rvfpm_mv_checker.sv
// rvfpm_mv_checker
// Scoreboard-style checker for FMV.X.W / FMV.W.X of an FP unit with a fixed
// PIPELINE_STAGES enabled-cycle issue-to-result latency. Each recognised move
// records its expected result in a delay line; when it reaches the end the
// DUT result (integer result or FP register write) is compared with it.
//
// Parameters: NUM_REGS (FP regs, max 256), PIPELINE_STAGES (1..16),
//             XLEN (operand width, max 64), CNT_W (counter width).
// Ports:
//   ck, rst                 : clock, synchronous active-high reset
//   enable                  : FP pipeline advance; low freezes the checker
//   instruction             : instruction issued this cycle
//   fpr_rdata               : FP register value at rs1 (same cycle)
//   data_fromXReg           : integer operand of the instruction
//   data_toXReg             : integer result from the DUT
//   fpr_we/waddr/wdata      : observed FP register-file write port
//   chk_cnt, err_cnt        : saturating check / failure counters
//   err_sticky              : set at first failure, cleared only by reset
//   mismatch                : combinational pulse in a failing check cycle
// Optional (macro RVFPM_CHK_FIRST_ERR_EN): first_err_valid, first_err_expected,
//   first_err_got, first_err_kind, first_err_time capture the first failure;
//   first_err_time is the enabled-cycle count since reset at that failure.
// The checker has no FSM and no handshakes; all state is the delay line,
// the counters and the optional first-error record.
module rvfpm_mv_checker
  import rvfpm_chk_pkg::*;
#(
  parameter int NUM_REGS        = 32,
  parameter int PIPELINE_STAGES = 4,
  parameter int XLEN            = 32,
  parameter int CNT_W           = 16
) (
  input  logic                        ck,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [31:0]                 instruction,
  input  logic [XLEN-1:0]             fpr_rdata,
  input  logic [XLEN-1:0]             data_fromXReg,
  input  logic [XLEN-1:0]             data_toXReg,
  input  logic                        fpr_we,
  input  logic [$clog2(NUM_REGS)-1:0] fpr_waddr,
  input  logic [XLEN-1:0]             fpr_wdata,
  output logic [CNT_W-1:0]            chk_cnt,
  output logic [CNT_W-1:0]            err_cnt,
  output logic                        err_sticky,
  output logic                        mismatch
`ifdef RVFPM_CHK_FIRST_ERR_EN
  ,
  output logic                        first_err_valid,
  output logic [XLEN-1:0]             first_err_expected,
  output logic [XLEN-1:0]             first_err_got,
  output logic                        first_err_kind,
  output logic [31:0]                 first_err_time
`endif
);

  localparam int IDX_W = $clog2(NUM_REGS);

  // ---------------------------------------------------------------- issue
  logic       is_x_w;
  logic       is_w_x;
  chk_entry_t push_entry;
  chk_entry_t tail_entry;

  assign is_x_w = is_fmv_x_w(instruction);
  assign is_w_x = is_fmv_w_x(instruction);

  always_comb begin
    push_entry = '0;
    if (is_x_w) begin
      push_entry.valid                = 1'b1;
      push_entry.kind                 = FMV_X_W;
      push_entry.rd[4:0]              = instruction[11:7];
      push_entry.expected[XLEN-1:0]   = fpr_rdata;
    end else if (is_w_x) begin
      push_entry.valid                = 1'b1;
      push_entry.kind                 = FMV_W_X;
      push_entry.rd[4:0]              = instruction[11:7];
      push_entry.expected[XLEN-1:0]   = data_fromXReg;
    end
  end

  rvfpm_chk_delay_line #(
    .DEPTH (PIPELINE_STAGES),
    .T     (chk_entry_t)
  ) u_delay_line (
    .ck     (ck),
    .rst    (rst),
    .enable (enable),
    .in     (push_entry),
    .out    (tail_entry)
  );

  // ---------------------------------------------------------------- check
  // DUT-side values are widened to the entry field widths so the compare
  // covers every stored bit.
  logic [CHK_DATA_W-1:0] got_x_ext;
  logic [CHK_DATA_W-1:0] wdata_ext;
  logic [CHK_RD_W-1:0]   waddr_ext;
  logic                  do_check;
  logic                  check_fail;

  always_comb begin
    got_x_ext              = '0;
    got_x_ext[XLEN-1:0]    = data_toXReg;
    wdata_ext              = '0;
    wdata_ext[XLEN-1:0]    = fpr_wdata;
    waddr_ext              = '0;
    waddr_ext[IDX_W-1:0]   = fpr_waddr;
  end

  // rst wins over enable: no check is ever performed during reset.
  assign do_check = !rst && enable && tail_entry.valid;

  // Case-equality so that an X/Z bit on the DUT side is a failure in
  // simulation rather than an unknown compare.
  always_comb begin
    check_fail = 1'b0;
    if (tail_entry.kind == FMV_X_W) begin
      check_fail = (got_x_ext !== tail_entry.expected);
    end else begin
      check_fail = !((fpr_we === 1'b1) &&
                     (waddr_ext === tail_entry.rd) &&
                     (wdata_ext === tail_entry.expected));
    end
  end

  assign mismatch = do_check && check_fail;

  // ------------------------------------------------------------- counters
  always_ff @(posedge ck) begin
    if (rst) begin
      chk_cnt    <= '0;
      err_cnt    <= '0;
      err_sticky <= 1'b0;
    end else if (do_check) begin
      if (chk_cnt != '1) begin
        chk_cnt <= chk_cnt + CNT_W'(1);
      end
      if (check_fail) begin
        if (err_cnt != '1) begin
          err_cnt <= err_cnt + CNT_W'(1);
        end
        err_sticky <= 1'b1;
      end
    end
  end

`ifdef RVFPM_CHK_FIRST_ERR_EN
  // ---------------------------------------------------- first-error record
  logic [31:0] time_cnt;

  always_ff @(posedge ck) begin
    if (rst) begin
      time_cnt           <= '0;
      first_err_valid    <= 1'b0;
      first_err_expected <= '0;
      first_err_got      <= '0;
      first_err_kind     <= 1'b0;
      first_err_time     <= '0;
    end else if (enable) begin
      time_cnt <= time_cnt + 32'd1;
      if (mismatch && !first_err_valid) begin
        first_err_valid    <= 1'b1;
        first_err_expected <= tail_entry.expected[XLEN-1:0];
        first_err_got      <= (tail_entry.kind == FMV_X_W) ? data_toXReg
                                                           : fpr_wdata;
        first_err_kind     <= logic'(tail_entry.kind);
        first_err_time     <= time_cnt;
      end
    end
  end
`endif

endmodule

// File: tb/tb_rvfpm_mv_checker.sv
// tb_rvfpm_mv_checker
// Randomised and directed bench for rvfpm_mv_checker. The bench plays the
// FP unit: it issues instructions and, in the cycle a result is due,
// drives a correct or deliberately wrong result. A queue-based model keyed
// on enabled-cycle numbers predicts checks, failures and counters.
// A second instance with CNT_W=4 shares all inputs to exercise saturation.
module tb_rvfpm_mv_checker;

  localparam int PIPE = 4;

  // ------------------------------------------------------- clock / reset
  logic ck = 1'b0;
  always #5 ck = ~ck;

  logic        rst;
  logic        enable;
  logic [31:0] instruction;
  logic [31:0] fpr_rdata;
  logic [31:0] data_fromXReg;
  logic [31:0] data_toXReg;
  logic        fpr_we;
  logic [4:0]  fpr_waddr;
  logic [31:0] fpr_wdata;

  logic [15:0] chk_cnt, err_cnt;
  logic        err_sticky, mismatch;
  logic [3:0]  chk_cnt_s, err_cnt_s;
  logic        err_sticky_s, mismatch_s;
`ifdef RVFPM_CHK_FIRST_ERR_EN
  logic        fe_valid, fe_kind, fe_valid_s, fe_kind_s;
  logic [31:0] fe_exp, fe_got, fe_time, fe_exp_s, fe_got_s, fe_time_s;
`endif

  rvfpm_mv_checker dut (
    .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
    .fpr_rdata(fpr_rdata), .data_fromXReg(data_fromXReg),
    .data_toXReg(data_toXReg), .fpr_we(fpr_we), .fpr_waddr(fpr_waddr),
    .fpr_wdata(fpr_wdata), .chk_cnt(chk_cnt), .err_cnt(err_cnt),
    .err_sticky(err_sticky), .mismatch(mismatch)
`ifdef RVFPM_CHK_FIRST_ERR_EN
    , .first_err_valid(fe_valid), .first_err_expected(fe_exp),
    .first_err_got(fe_got), .first_err_kind(fe_kind), .first_err_time(fe_time)
`endif
  );

  rvfpm_mv_checker #(.CNT_W(4)) dut_s (
    .ck(ck), .rst(rst), .enable(enable), .instruction(instruction),
    .fpr_rdata(fpr_rdata), .data_fromXReg(data_fromXReg),
    .data_toXReg(data_toXReg), .fpr_we(fpr_we), .fpr_waddr(fpr_waddr),
    .fpr_wdata(fpr_wdata), .chk_cnt(chk_cnt_s), .err_cnt(err_cnt_s),
    .err_sticky(err_sticky_s), .mismatch(mismatch_s)
`ifdef RVFPM_CHK_FIRST_ERR_EN
    , .first_err_valid(fe_valid_s), .first_err_expected(fe_exp_s),
    .first_err_got(fe_got_s), .first_err_kind(fe_kind_s),
    .first_err_time(fe_time_s)
`endif
  );

  // ------------------------------------------------------------ reference
  typedef struct {
    int          due;   // enabled-cycle number at which the check happens
    bit          kind;  // 0: FMV.X.W, 1: FMV.W.X
    logic [4:0]  rd;
    logic [31:0] val;
  } op_t;

  op_t         exp_q[$];
  int          ecnt;     // enabled cycles since reset
  int          m_chk, m_err;
  bit          m_sticky;
  bit          m_fe_valid, m_fe_kind;
  logic [31:0] m_fe_exp, m_fe_got;
  int          m_fe_time;
  logic [31:0] got_override;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string tag, input logic [63:0] got,
                       input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // 0: not a move, 1: FMV.X.W, 2: FMV.W.X
  function automatic int decode(input logic [31:0] insn);
    if (insn[6:0] != 7'h53 || insn[14:12] != 3'd0 || insn[24:20] != 5'd0)
      return 0;
    if (insn[31:25] == 7'h70) return 1;
    if (insn[31:25] == 7'h78) return 2;
    return 0;
  endfunction

  function automatic logic [31:0] enc(input bit kind, input logic [4:0] rd,
                                      input logic [4:0] rs1);
    logic [6:0] f7;
    f7 = kind ? 7'h78 : 7'h70;
    return {f7, 5'd0, rs1, 3'd0, rd, 7'h53};
  endfunction

  function automatic logic [31:0] rand_insn();
    int          sel;
    logic [31:0] w;
    sel = $urandom_range(0, 9);
    w   = enc(sel >= 4, 5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)));
    if (sel == 9) return $urandom;
    if (sel >= 7) begin
      case ($urandom_range(0, 3))
        0:       w = w ^ 32'h0000_1000;  // funct3
        1:       w = w ^ 32'h0010_0000;  // rs2
        2:       w = w ^ 32'h0000_0001;  // opcode
        default: w = w ^ 32'h0200_0000;  // funct7 bit 0
      endcase
    end
    return w;
  endfunction

  // ------------------------------------------------------------ driver
  // resp_mode for a due check: 0 random, 1 pass, 2 fail,
  // 3 fail via wrong write address, 4 drive got_override as the X result.
  task automatic cycle(input int resp_mode);
    bit  due;
    bit  fail_exp;
    op_t h;
    int  sel;
    int  k;
    due      = 0;
    fail_exp = 0;
    data_toXReg = $urandom;
    fpr_we      = 1'($urandom_range(0, 1));
    fpr_waddr   = 5'($urandom_range(0, 31));
    fpr_wdata   = $urandom;
    if (!rst && enable && exp_q.size() > 0 && exp_q[0].due == ecnt) begin
      due = 1;
      h   = exp_q[0];
      fail_exp = (resp_mode == 0) ? bit'($urandom_range(0, 1)) : (resp_mode != 1);
      if (h.kind == 0) begin
        if (resp_mode == 4) begin
          data_toXReg = got_override;
          fail_exp    = (got_override != h.val);
        end else if (fail_exp) begin
          data_toXReg = h.val ^ (32'h1 << $urandom_range(0, 31));
        end else begin
          data_toXReg = h.val;
        end
      end else begin
        fpr_we    = 1'b1;
        fpr_waddr = h.rd;
        fpr_wdata = h.val;
        if (resp_mode == 4) fail_exp = 0;
        if (fail_exp) begin
          sel = (resp_mode == 3) ? 1 : $urandom_range(0, 2);
          case (sel)
            0:       fpr_we    = 1'b0;
            1:       fpr_waddr = h.rd + 5'd1;
            default: fpr_wdata = h.val ^ (32'h1 << $urandom_range(0, 31));
          endcase
        end
      end
    end
    @(negedge ck);
    check("mismatch", {63'd0, mismatch}, {63'd0, fail_exp});
    check("mismatch_s", {63'd0, mismatch_s}, {63'd0, fail_exp});
    @(posedge ck);
    if (rst) begin
      exp_q.delete();
      ecnt = 0; m_chk = 0; m_err = 0; m_sticky = 0;
      m_fe_valid = 0; m_fe_kind = 0; m_fe_exp = 0; m_fe_got = 0; m_fe_time = 0;
    end else if (enable) begin
      if (due) begin
        void'(exp_q.pop_front());
        m_chk++;
        if (fail_exp) begin
          if (!m_fe_valid) begin
            m_fe_valid = 1;
            m_fe_kind  = h.kind;
            m_fe_exp   = h.val;
            m_fe_got   = h.kind ? fpr_wdata : data_toXReg;
            m_fe_time  = ecnt;
          end
          m_err++;
          m_sticky = 1;
        end
      end
      k = decode(instruction);
      if (k != 0) begin
        h.due  = ecnt + PIPE;
        h.kind = (k == 2);
        h.rd   = instruction[11:7];
        h.val  = (k == 2) ? data_fromXReg : fpr_rdata;
        exp_q.push_back(h);
      end
      ecnt++;
    end
    #1;
    check("chk_cnt", 64'(chk_cnt), 64'(sat(m_chk, 65535)));
    check("err_cnt", 64'(err_cnt), 64'(sat(m_err, 65535)));
    check("err_sticky", 64'(err_sticky), 64'(m_sticky));
    check("chk_cnt_s", 64'(chk_cnt_s), 64'(sat(m_chk, 15)));
    check("err_cnt_s", 64'(err_cnt_s), 64'(sat(m_err, 15)));
`ifdef RVFPM_CHK_FIRST_ERR_EN
    check("fe_valid", 64'(fe_valid), 64'(m_fe_valid));
    check("fe_expected", 64'(fe_exp), 64'(m_fe_exp));
    check("fe_got", 64'(fe_got), 64'(m_fe_got));
    check("fe_kind", 64'(fe_kind), 64'(m_fe_kind));
    check("fe_time", 64'(fe_time), 64'(m_fe_time));
`endif
  endtask

  task automatic run(input logic r, input logic en, input logic [31:0] insn,
                     input logic [31:0] frs, input logic [31:0] xop,
                     input int resp_mode);
    rst = r; enable = en; instruction = insn;
    fpr_rdata = frs; data_fromXReg = xop;
    cycle(resp_mode);
  endtask

  task automatic idle(input int n, input logic en, input int resp_mode);
    for (int i = 0; i < n; i++) run(1'b0, en, 32'd0, $urandom, $urandom, resp_mode);
  endtask

  task automatic do_reset(input int n);
    for (int i = 0; i < n; i++) run(1'b1, 1'($urandom_range(0, 1)), rand_insn(), $urandom, $urandom, 0);
  endtask

  // ------------------------------------------------------------ sequence
  initial begin
    rst = 1'b1; enable = 1'b0; instruction = '0; fpr_rdata = '0;
    data_fromXReg = '0; data_toXReg = '0; fpr_we = 1'b0; fpr_waddr = '0;
    fpr_wdata = '0; got_override = '0;
    ecnt = 0; m_chk = 0; m_err = 0; m_sticky = 0;
    m_fe_valid = 0; m_fe_kind = 0; m_fe_exp = 0; m_fe_got = 0; m_fe_time = 0;
    @(posedge ck);
    #1;

    do_reset(3);
    check("reset_chk_cnt", 64'(chk_cnt), 64'd0);
    check("reset_err_cnt", 64'(err_cnt), 64'd0);

    // Passing FMV.X.W, result four enabled cycles later.
    run(1'b0, 1'b1, enc(0, 5'd1, 5'd3), 32'h3F80_0000, $urandom, 1);
    idle(PIPE, 1'b1, 1);
    check("pass_xw_chk", 64'(chk_cnt), 64'd1);
    check("pass_xw_err", 64'(err_cnt), 64'd0);

    // Same op, wrong result.
    do_reset(1);
    got_override = 32'h4000_0000;
    run(1'b0, 1'b1, enc(0, 5'd1, 5'd3), 32'h3F80_0000, $urandom, 4);
    idle(PIPE, 1'b1, 4);
    check("fail_xw_err", 64'(err_cnt), 64'd1);
    check("fail_xw_sticky", 64'(err_sticky), 64'd1);
`ifdef RVFPM_CHK_FIRST_ERR_EN
    check("fail_xw_fe_exp", 64'(fe_exp), 64'h3F80_0000);
    check("fail_xw_fe_got", 64'(fe_got), 64'h4000_0000);
`endif

    // FMV.W.X to rd=5 written to register 6, then to register 5.
    do_reset(1);
    run(1'b0, 1'b1, enc(1, 5'd5, 5'd0), $urandom, 32'hDEAD_BEEF, 3);
    idle(PIPE, 1'b1, 3);
    check("wx_bad_addr_err", 64'(err_cnt), 64'd1);
    run(1'b0, 1'b1, enc(1, 5'd5, 5'd0), $urandom, 32'hDEAD_BEEF, 1);
    idle(PIPE, 1'b1, 1);
    check("wx_good_addr_chk", 64'(chk_cnt), 64'd2);
    check("wx_good_addr_err", 64'(err_cnt), 64'd1);

    // Stall: nothing checked while enable is low.
    do_reset(1);
    run(1'b0, 1'b1, enc(0, 5'd2, 5'd4), $urandom, $urandom, 1);
    idle(10, 1'b0, 1);
    idle(PIPE - 1, 1'b1, 1);
    check("stall_before", 64'(chk_cnt), 64'd0);
    idle(1, 1'b1, 1);
    check("stall_after", 64'(chk_cnt), 64'd1);

    // Reset while ops are in flight discards them.
    do_reset(1);
    run(1'b0, 1'b1, enc(0, 5'd1, 5'd1), $urandom, $urandom, 2);
    run(1'b0, 1'b1, enc(1, 5'd2, 5'd2), $urandom, $urandom, 2);
    run(1'b1, 1'b1, enc(0, 5'd3, 5'd3), $urandom, $urandom, 2);
    idle(2 * PIPE, 1'b1, 2);
    check("flush_chk", 64'(chk_cnt), 64'd0);
    check("flush_err", 64'(err_cnt), 64'd0);

    // Randomised traffic.
    do_reset(1);
    for (int i = 0; i < 500; i++) begin
      run(1'($urandom_range(0, 99) == 0), 1'($urandom_range(0, 99) < 80),
          rand_insn(), $urandom, $urandom, 0);
    end

    // Saturation of the 4-bit counters: 20 failing checks.
    do_reset(1);
    for (int i = 0; i < 20; i++) begin
      run(1'b0, 1'b1, enc(1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
          5'($urandom_range(0, 31))), $urandom, $urandom, 2);
    end
    idle(PIPE, 1'b1, 2);
    check("sat_err_s", 64'(err_cnt_s), 64'd15);
    check("sat_chk_s", 64'(chk_cnt_s), 64'd15);
    check("sat_err_wide", 64'(err_cnt), 64'd20);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
